// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack and sticky flags.
// Priority per cycle is stall > ret > call > jump > increment.
module pc_stack_unit #(
  parameter int                 WIDTH     = 32,
  parameter int                 STEP      = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0,
  parameter int                 DEPTH     = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     stall,
  input  logic                     jump,
  input  logic                     call,
  input  logic                     ret,
  input  logic [WIDTH-1:0]         target,
  input  logic                     flag_clr,
  output logic [WIDTH-1:0]         pc,
  output logic [$clog2(DEPTH):0]   depth_cnt,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);

  logic [WIDTH-1:0] stack_r [DEPTH];
  logic [WIDTH-1:0] pc_r;
  logic [PW-1:0]    top_r;
  logic [CW-1:0]    depth_r;
  logic             ovf_r;
  logic             unf_r;

  logic [WIDTH-1:0] seq_s;
  logic [WIDTH-1:0] pc_nx_s;
  logic [PW-1:0]    top_nx_s;
  logic [CW-1:0]    depth_nx_s;
  logic             ovf_nx_s;
  logic             unf_nx_s;
  logic             push_s;

  assign seq_s = pc_r + STEP_V;

  // Next-state selection; top_r names the current top entry, a push writes one slot above it.
  always_comb begin
    pc_nx_s    = pc_r;
    top_nx_s   = top_r;
    depth_nx_s = depth_r;
    ovf_nx_s   = ovf_r;
    unf_nx_s   = unf_r;
    push_s     = 1'b0;
    if (stall) begin
      pc_nx_s = pc_r;
    end else begin
      if (flag_clr) begin
        ovf_nx_s = 1'b0;
        unf_nx_s = 1'b0;
      end else begin
        ovf_nx_s = ovf_r;
      end
      if (ret) begin
        if (depth_r != CNT_ZERO) begin
          pc_nx_s    = stack_r[top_r];
          top_nx_s   = top_r - PTR_ONE;
          depth_nx_s = depth_r - CNT_ONE;
        end else begin
          pc_nx_s  = seq_s;
          unf_nx_s = 1'b1;
        end
      end else if (call) begin
        pc_nx_s  = target;
        push_s   = 1'b1;
        top_nx_s = top_r + PTR_ONE;
        // When full the slot above top is the oldest entry, so it is overwritten in place.
        if (depth_r == FULL) begin
          ovf_nx_s = 1'b1;
        end else begin
          depth_nx_s = depth_r + CNT_ONE;
        end
      end else if (jump) begin
        pc_nx_s = target;
      end else begin
        pc_nx_s = seq_s;
      end
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc_r    <= RESET_VEC;
      top_r   <= '0;
      depth_r <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pc_r    <= pc_nx_s;
      top_r   <= top_nx_s;
      depth_r <= depth_nx_s;
      ovf_r   <= ovf_nx_s;
      unf_r   <= unf_nx_s;
    end
  end

  // Stack storage is not reset; entries are only readable while depth_r is non-zero.
  always_ff @(posedge clock) begin
    if (push_s) begin
      stack_r[top_nx_s] <= seq_s;
    end
  end

  assign pc        = pc_r;
  assign depth_cnt = depth_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;

  pc_stack_unit_chk #(.DEPTH(DEPTH)) u_chk (
    .clock     (clock),
    .clear     (clear),
    .depth_cnt (depth_r)
  );

endmodule

// Structural checks on the stack occupancy.
module pc_stack_unit_chk #(
  parameter int DEPTH = 8
) (
  input logic                     clock,
  input logic                     clear,
  input logic [$clog2(DEPTH):0]   depth_cnt
);

  localparam logic [$clog2(DEPTH):0] FULL = ($clog2(DEPTH)+1)'(DEPTH);

  initial begin
    assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)
      else $error("DEPTH must be a power of two and at least 2");
  end

  a_depth_bound: assert property (@(posedge clock) disable iff (clear) depth_cnt <= FULL)
    else $error("depth_cnt exceeds DEPTH");

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with WIDTH=32, STEP=4, RESET_VEC=0x100, DEPTH=4.
module tb_pc_stack_unit;

  logic        clock;
  logic        clear;
  logic        stall;
  logic        jump;
  logic        call;
  logic        ret;
  logic [31:0] target;
  logic        flag_clr;
  logic [31:0] pc;
  logic [2:0]  depth_cnt;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_stack_unit #(
    .WIDTH(32), .STEP(4), .RESET_VEC(32'h0000_0100), .DEPTH(4)
  ) dut (
    .clock(clock), .clear(clear), .stall(stall), .jump(jump), .call(call),
    .ret(ret), .target(target), .flag_clr(flag_clr), .pc(pc),
    .depth_cnt(depth_cnt), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic state(input string tag, input logic [31:0] e_pc, input logic [2:0] e_d,
                       input logic e_ovf, input logic e_unf);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".depth"}, 32'(depth_cnt), 32'(e_d));
    check({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(e_unf));
  endtask

  initial begin
    clear = 1'b1; target = 32'h0; idle();
    #1;
    state("reset", 32'h100, 3'd0, 1'b0, 1'b0);

    // Requests are ignored while clear is held.
    jump = 1'b1; target = 32'h0000_0999;
    step();
    state("clear_hold", 32'h100, 3'd0, 1'b0, 1'b0);

    clear = 1'b0; idle();
    step(); check("inc1", pc, 32'h104);
    step(); check("inc2", pc, 32'h108);
    step(); check("inc3", pc, 32'h10C);

    jump = 1'b1; target = 32'hFFFF_FFFC;
    step(); check("jump_top", pc, 32'hFFFF_FFFC);
    idle();
    step(); state("wrap", 32'h0, 3'd0, 1'b0, 1'b0);

    jump = 1'b1; target = 32'h200;
    step(); state("jump200", 32'h200, 3'd0, 1'b0, 1'b0);
    jump = 1'b0; call = 1'b1; target = 32'h400;
    step(); state("call400", 32'h400, 3'd1, 1'b0, 1'b0);
    call = 1'b0; ret = 1'b1;
    step(); state("ret204", 32'h204, 3'd0, 1'b0, 1'b0);

    ret = 1'b0; jump = 1'b1; target = 32'h10;
    step(); check("jump10", pc, 32'h10);
    jump = 1'b0; call = 1'b1;
    target = 32'h20; step(); state("call1", 32'h20, 3'd1, 1'b0, 1'b0);
    target = 32'h30; step(); state("call2", 32'h30, 3'd2, 1'b0, 1'b0);
    target = 32'h40; step(); state("call3", 32'h40, 3'd3, 1'b0, 1'b0);
    target = 32'h50; step(); state("call4", 32'h50, 3'd4, 1'b0, 1'b0);
    target = 32'h60; step(); state("call5_ovf", 32'h60, 3'd4, 1'b1, 1'b0);

    call = 1'b0; ret = 1'b1;
    step(); state("ret1", 32'h54, 3'd3, 1'b1, 1'b0);
    step(); state("ret2", 32'h44, 3'd2, 1'b1, 1'b0);
    step(); state("ret3", 32'h34, 3'd1, 1'b1, 1'b0);
    step(); state("ret4", 32'h24, 3'd0, 1'b1, 1'b0);
    step(); state("ret5_unf", 32'h28, 3'd0, 1'b1, 1'b1);

    // Stall beats jump and flag_clr.
    ret = 1'b0; stall = 1'b1; jump = 1'b1; flag_clr = 1'b1; target = 32'h777;
    step(); state("stall", 32'h28, 3'd0, 1'b1, 1'b1);

    idle(); call = 1'b1; target = 32'h300;
    step(); state("call300", 32'h300, 3'd1, 1'b1, 1'b1);
    call = 1'b1; ret = 1'b1; jump = 1'b1; target = 32'h500;
    step(); state("ret_only", 32'h2C, 3'd0, 1'b1, 1'b1);

    idle(); flag_clr = 1'b1;
    step(); state("flag_clr", 32'h30, 3'd0, 1'b0, 1'b0);

    // Underflow set wins over flag_clr in the same cycle.
    ret = 1'b1; flag_clr = 1'b1;
    step(); state("set_wins", 32'h34, 3'd0, 1'b0, 1'b1);

    // Asynchronous clear during stall, between edges.
    idle(); call = 1'b1; target = 32'h900;
    step(); check("call900", 32'(depth_cnt), 32'd1);
    idle(); stall = 1'b1;
    #2; clear = 1'b1;
    #1; state("async_clr", 32'h100, 3'd0, 1'b0, 1'b0);
    clear = 1'b0; stall = 1'b0;
    step(); state("post_clr", 32'h104, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
